// File: rtl/plot_pkg.sv
// Shared constants and types for the sprite plotter datapath.
package plot_pkg;

  // Screen geometry
  localparam logic [7:0] SCREEN_W  = 8'd160;
  localparam logic [6:0] SCREEN_H  = 7'd120;

  // Sprite geometry
  localparam logic [7:0] BIRD_X    = 8'd40;
  localparam logic [3:0] BIRD_SIZE = 4'd4;
  localparam logic [3:0] PIPE_W    = 4'd8;
  localparam logic [7:0] GAP_H     = 8'd32;

  // Colours
  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] BIRD_COLOUR = 3'b110;
  localparam logic [2:0] PIPE_COLOUR = 3'b010;

  // Pass lengths in plot slots
  localparam int unsigned BIRD_PIXELS  = 16;
  localparam int unsigned PIPE_PIXELS  = 960;
  localparam int unsigned CLEAR_PIXELS = 19200;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StClearDone,
    StBird,
    StPipe,
    StDone
  } plot_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major column/row scan counter with a run-time selectable window size.
module raster_counter #(
  parameter int unsigned ColBits = 8,
  parameter int unsigned RowBits = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic [ColBits-1:0] width,
  input  logic [RowBits-1:0] height,
  output logic [ColBits-1:0] col,
  output logic [RowBits-1:0] row,
  output logic               last
);

  localparam logic [ColBits-1:0] ColOne = 1;
  localparam logic [RowBits-1:0] RowOne = 1;

  logic [ColBits-1:0] col_q;
  logic [RowBits-1:0] row_q;
  logic               col_end;
  logic               row_end;

  assign col_end = (col_q == width - ColOne);
  assign row_end = (row_q == height - RowOne);
  assign last    = col_end && row_end;
  assign col     = col_q;
  assign row     = row_q;

  // Advance column first; on the final column wrap and step the row, wrapping at the window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + RowOne;
      end else begin
        col_q <= col_q + ColOne;
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Pixel generator: full-screen clear sweep plus bird/pipe erase or draw passes.
module sprite_plotter
  import plot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       loadEnableDataPath,
  input  logic       oldOrCurrent,
  input  logic       plotEnable,
  input  logic       clrCanvasScreenEnable,
  input  logic       clrCanvasXYOrRetainXYToVGA,
  input  logic [6:0] birdYCur,
  input  logic [6:0] birdYOld,
  input  logic [7:0] pipeXCur,
  input  logic [7:0] pipeXOld,
  input  logic [6:0] gapYCur,
  input  logic [6:0] gapYOld,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       outputFinish,
  output logic       clrCanvasFinish
);

  plot_state_t state_q, state_d;

  logic [6:0] bird_y_q;
  logic [7:0] pipe_x_q;
  logic [6:0] gap_y_q;
  logic       erase_q;

  logic       clr_strobe;
  logic       load_strobe;
  logic       clear_step;
  logic       sprite_step;

  logic [7:0] cx;
  logic [6:0] cy;
  logic       clr_last;

  logic [3:0] sc;
  logic [6:0] sr;
  logic       spr_last;
  logic [3:0] spr_w;
  logic [6:0] spr_h;

  logic [7:0] bird_x;
  logic [7:0] bird_y_sum;
  logic [8:0] pipe_x_sum;
  logic [7:0] gap_end;
  logic       in_gap;
  logic [7:0] spr_x;
  logic [6:0] spr_y;
  logic [2:0] spr_colour;
  logic       spr_visible;

  // A clear strobe overrides a simultaneous load; neither strobe cycle consumes a pixel slot.
  assign clr_strobe  = clrCanvasScreenEnable;
  assign load_strobe = loadEnableDataPath && !clrCanvasScreenEnable;
  assign clear_step  = plotEnable && !clrCanvasXYOrRetainXYToVGA && (state_q == StClear) &&
                       !clr_strobe && !loadEnableDataPath;
  assign sprite_step = plotEnable && ((state_q == StBird) || (state_q == StPipe)) &&
                       !clr_strobe && !loadEnableDataPath;

  // The sprite counter is reused for both phases; it wraps to (0,0) at the bird/pipe boundary.
  assign spr_w = (state_q == StPipe) ? PIPE_W : BIRD_SIZE;
  assign spr_h = (state_q == StPipe) ? SCREEN_H : {3'd0, BIRD_SIZE};

  raster_counter #(
    .ColBits(8),
    .RowBits(7)
  ) u_clear_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (clr_strobe),
    .inc   (clear_step),
    .width (SCREEN_W),
    .height(SCREEN_H),
    .col   (cx),
    .row   (cy),
    .last  (clr_last)
  );

  raster_counter #(
    .ColBits(4),
    .RowBits(7)
  ) u_sprite_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (load_strobe),
    .inc   (sprite_step),
    .width (spr_w),
    .height(spr_h),
    .col   (sc),
    .row   (sr),
    .last  (spr_last)
  );

  // Sprite pixel coordinate, colour and on-screen/out-of-gap visibility for the current slot.
  always_comb begin
    bird_x      = BIRD_X + {4'd0, sc};
    bird_y_sum  = {1'b0, bird_y_q} + {1'b0, sr};
    pipe_x_sum  = {1'b0, pipe_x_q} + {5'd0, sc};
    gap_end     = {1'b0, gap_y_q} + GAP_H;
    in_gap      = ({1'b0, sr} >= {1'b0, gap_y_q}) && ({1'b0, sr} < gap_end);
    spr_x       = bird_x;
    spr_y       = bird_y_sum[6:0];
    spr_visible = (bird_y_sum < {1'b0, SCREEN_H});
    spr_colour  = erase_q ? BG_COLOUR : BIRD_COLOUR;
    if (state_q == StPipe) begin
      spr_x       = pipe_x_sum[7:0];
      spr_y       = sr;
      spr_visible = (pipe_x_sum < {1'b0, SCREEN_W}) && !in_gap;
      spr_colour  = erase_q ? BG_COLOUR : PIPE_COLOUR;
    end
  end

  // Next-state logic: strobes redirect from any state, passes end on their last counted slot.
  always_comb begin
    state_d = state_q;
    if (clr_strobe) begin
      state_d = StClear;
    end else if (load_strobe) begin
      state_d = StBird;
    end else begin
      case (state_q)
        StClear: if (clear_step && clr_last)  state_d = StClearDone;
        StBird:  if (sprite_step && spr_last) state_d = StPipe;
        StPipe:  if (sprite_step && spr_last) state_d = StDone;
        default: state_d = state_q;
      endcase
    end
  end

  // State register and position/mode snapshot taken on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      bird_y_q <= '0;
      pipe_x_q <= '0;
      gap_y_q  <= '0;
      erase_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_strobe) begin
        bird_y_q <= oldOrCurrent ? birdYCur : birdYOld;
        pipe_x_q <= oldOrCurrent ? pipeXCur : pipeXOld;
        gap_y_q  <= oldOrCurrent ? gapYCur  : gapYOld;
        erase_q  <= !oldOrCurrent;
      end
    end
  end

  // Registered pixel outputs through the clear/sprite source mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else if (!clrCanvasXYOrRetainXYToVGA) begin
      x       <= cx;
      y       <= cy;
      colour  <= BG_COLOUR;
      writeEn <= clear_step;
    end else begin
      x       <= spr_x;
      y       <= spr_y;
      colour  <= spr_colour;
      writeEn <= sprite_step && spr_visible;
    end
  end

  // Finish flags rise with the final pixel and hold until the next relevant strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outputFinish    <= 1'b0;
      clrCanvasFinish <= 1'b0;
    end else if (clr_strobe) begin
      outputFinish    <= 1'b0;
      clrCanvasFinish <= 1'b0;
    end else begin
      if (load_strobe) begin
        outputFinish <= 1'b0;
      end else if (sprite_step && spr_last && (state_q == StPipe)) begin
        outputFinish <= 1'b1;
      end
      if (clear_step && clr_last) begin
        clrCanvasFinish <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: table-driven and random sprite passes, clears, resets.
module tb_sprite_plotter;
  import plot_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadEnableDataPath;
  logic       oldOrCurrent;
  logic       plotEnable;
  logic       clrCanvasScreenEnable;
  logic       clrCanvasXYOrRetainXYToVGA;
  logic [6:0] birdYCur, birdYOld;
  logic [7:0] pipeXCur, pipeXOld;
  logic [6:0] gapYCur, gapYOld;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;
  logic       outputFinish;
  logic       clrCanvasFinish;

  always #5 clk = ~clk;

  sprite_plotter dut (
    .clk                       (clk),
    .reset                     (reset),
    .loadEnableDataPath        (loadEnableDataPath),
    .oldOrCurrent              (oldOrCurrent),
    .plotEnable                (plotEnable),
    .clrCanvasScreenEnable     (clrCanvasScreenEnable),
    .clrCanvasXYOrRetainXYToVGA(clrCanvasXYOrRetainXYToVGA),
    .birdYCur                  (birdYCur),
    .birdYOld                  (birdYOld),
    .pipeXCur                  (pipeXCur),
    .pipeXOld                  (pipeXOld),
    .gapYCur                   (gapYCur),
    .gapYOld                   (gapYOld),
    .x                         (x),
    .y                         (y),
    .colour                    (colour),
    .writeEn                   (writeEn),
    .outputFinish              (outputFinish),
    .clrCanvasFinish           (clrCanvasFinish)
  );

  typedef struct {
    int by;
    int px;
    int gy;
    bit ooc;
    int writes;
  } vec_t;

  localparam int NSlots = 976;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_we[NSlots];
  int exp_x[NSlots];
  int exp_y[NSlots];
  int exp_c[NSlots];
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference pixel list for one pass, straight from the geometric rules.
  task automatic build_model(input int by, input int px, input int gy, input bit ooc);
    int n = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_we[n] = ((by + r) < 120) ? 1 : 0;
        exp_x[n]  = 40 + c;
        exp_y[n]  = by + r;
        exp_c[n]  = ooc ? 6 : 0;
        n++;
      end
    end
    for (int row = 0; row < 120; row++) begin
      for (int c = 0; c < 8; c++) begin
        exp_we[n] = ((px + c) < 160 && !(row >= gy && row < gy + 32)) ? 1 : 0;
        exp_x[n]  = px + c;
        exp_y[n]  = row;
        exp_c[n]  = ooc ? 2 : 0;
        n++;
      end
    end
  endtask

  task automatic do_load(input int by, input int px, input int gy, input bit ooc);
    clrCanvasXYOrRetainXYToVGA = 1'b1;
    plotEnable = 1'b0;
    if (ooc) begin
      birdYCur = 7'(by); pipeXCur = 8'(px); gapYCur = 7'(gy);
      birdYOld = 7'($urandom); pipeXOld = 8'($urandom_range(0, 159)); gapYOld = 7'($urandom);
    end else begin
      birdYOld = 7'(by); pipeXOld = 8'(px); gapYOld = 7'(gy);
      birdYCur = 7'($urandom); pipeXCur = 8'($urandom_range(0, 159)); gapYCur = 7'($urandom);
    end
    oldOrCurrent = ooc;
    loadEnableDataPath = 1'b1;
    tick();
    loadEnableDataPath = 1'b0;
    check("load_finish_low", outputFinish, 0);
    check("load_we_low", writeEn, 0);
  endtask

  // Plot `count` slots from the start of a pass, optionally pausing every other cycle.
  task automatic run_slots(input int count, input bit pause, output int writes);
    int idx = 0;
    int cyc = 0;
    bit pe;
    writes = 0;
    while (idx < count && cyc < 4000) begin
      pe = !pause || (cyc % 2 == 0);
      plotEnable = pe;
      tick();
      cyc++;
      if (pe) begin
        check($sformatf("slot%0d_we", idx), writeEn, exp_we[idx]);
        if (writeEn) writes++;
        if (writeEn && exp_we[idx] == 1) begin
          check($sformatf("slot%0d_x", idx), x, exp_x[idx]);
          check($sformatf("slot%0d_y", idx), y, exp_y[idx]);
          check($sformatf("slot%0d_colour", idx), colour, exp_c[idx]);
        end
        check($sformatf("slot%0d_finish", idx), outputFinish, (idx == NSlots - 1) ? 1 : 0);
        idx++;
      end else begin
        check($sformatf("pause%0d_we", idx), writeEn, 0);
      end
    end
    plotEnable = 1'b0;
    if (idx < count) check("slot_timeout", idx, count);
  endtask

  task automatic after_pass;
    plotEnable = 1'b1;
    tick();
    plotEnable = 1'b0;
    check("done_we", writeEn, 0);
    check("done_finish", outputFinish, 1);
  endtask

  task automatic start_clear(input bit with_load);
    clrCanvasXYOrRetainXYToVGA = 1'b0;
    plotEnable = 1'b0;
    clrCanvasScreenEnable = 1'b1;
    loadEnableDataPath = with_load;
    oldOrCurrent = 1'b1;
    tick();
    clrCanvasScreenEnable = 1'b0;
    loadEnableDataPath = 1'b0;
    check("clr_start_finish", clrCanvasFinish, 0);
    check("clr_start_out_finish", outputFinish, 0);
    check("clr_start_we", writeEn, 0);
  endtask

  task automatic run_clear(input int npix);
    for (int i = 0; i < npix; i++) begin
      plotEnable = 1'b1;
      tick();
      check($sformatf("clr%0d_we", i), writeEn, 1);
      check($sformatf("clr%0d_colour", i), colour, 0);
      check($sformatf("clr%0d_x", i), x, i % 160);
      check($sformatf("clr%0d_y", i), y, i / 160);
      check($sformatf("clr%0d_finish", i), clrCanvasFinish, (i == 160 * 120 - 1) ? 1 : 0);
    end
    plotEnable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_we"}, writeEn, 0);
    check({tag, "_out_finish"}, outputFinish, 0);
    check({tag, "_clr_finish"}, clrCanvasFinish, 0);
  endtask

  initial begin
    int w;
    int by, px, gy;
    bit ooc;

    vecs[0] = '{by: 50,  px: 100, gy: 40,  ooc: 1'b1, writes: 720};
    vecs[1] = '{by: 50,  px: 100, gy: 40,  ooc: 1'b0, writes: 720};
    vecs[2] = '{by: 118, px: 156, gy: 40,  ooc: 1'b1, writes: 360};
    vecs[3] = '{by: 10,  px: 0,   gy: 0,   ooc: 1'b1, writes: 720};
    vecs[4] = '{by: 100, px: 152, gy: 100, ooc: 1'b1, writes: 816};
    vecs[5] = '{by: 119, px: 159, gy: 88,  ooc: 1'b0, writes: 92};
    vecs[6] = '{by: 127, px: 0,   gy: 127, ooc: 1'b1, writes: 960};

    reset = 1'b1;
    loadEnableDataPath = 1'b0;
    oldOrCurrent = 1'b0;
    plotEnable = 1'b0;
    clrCanvasScreenEnable = 1'b0;
    clrCanvasXYOrRetainXYToVGA = 1'b0;
    birdYCur = '0; birdYOld = '0;
    pipeXCur = '0; pipeXOld = '0;
    gapYCur = '0; gapYOld = '0;
    #12;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Full clear sweep; plotEnable afterwards has no effect.
    start_clear(1'b0);
    run_clear(CLEAR_PIXELS);
    plotEnable = 1'b1;
    tick();
    plotEnable = 1'b0;
    check("clr_done_we", writeEn, 0);
    check("clr_done_finish", clrCanvasFinish, 1);

    // Table-driven passes, including clipping at the right and bottom edges.
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].by, vecs[i].px, vecs[i].gy, vecs[i].ooc);
      build_model(vecs[i].by, vecs[i].px, vecs[i].gy, vecs[i].ooc);
      run_slots(NSlots, 1'b0, w);
      check($sformatf("vec%0d_writes", i), w, vecs[i].writes);
      after_pass();
    end

    // Random passes against the model.
    for (int i = 0; i < 6; i++) begin
      by  = $urandom_range(0, 127);
      px  = $urandom_range(0, 159);
      gy  = $urandom_range(0, 127);
      ooc = 1'($urandom);
      do_load(by, px, gy, ooc);
      build_model(by, px, gy, ooc);
      run_slots(NSlots, 1'b0, w);
      after_pass();
    end

    // Half-rate plotting gives the same pixel sequence.
    do_load(50, 100, 40, 1'b1);
    build_model(50, 100, 40, 1'b1);
    run_slots(NSlots, 1'b1, w);
    check("pause_writes", w, 720);
    after_pass();

    // Reload at slot 300 restarts from the bird without a stale finish.
    do_load(60, 30, 10, 1'b1);
    build_model(60, 30, 10, 1'b1);
    run_slots(300, 1'b0, w);
    do_load(60, 30, 10, 1'b1);
    run_slots(NSlots, 1'b0, w);
    check("restart_writes", w, 720);
    after_pass();

    // Clear strobe wins over a simultaneous load; reset aborts mid-sweep.
    start_clear(1'b1);
    run_clear(5000);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    #2;
    reset = 1'b0;
    tick();
    check_all_zero("post_reset");
    start_clear(1'b0);
    run_clear(CLEAR_PIXELS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
